muldiv_sequencer: RTL

//   Multi-cycle sequencer for the RV32M multiply/divide operations. It sits beside the EX-stage ALU,

---
 rtl/muldiv_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide,
// one iteration per cycle, with single-cycle fast paths for divide-by-zero and signed overflow.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0]   ONE  = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE2 = (2*XLEN)'(1);
    localparam logic [XLEN-1:0]   SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Accept-cycle decode on the live inputs
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg, res_neg;
    logic            div0, ovf, fast;
    logic [XLEN-1:0] a_abs, b_abs, fast_val;

    assign is_div  = funct3[2];
    assign a_sgn   = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_sgn   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign a_neg   = a_sgn & rs1_data[XLEN-1];
    assign b_neg   = b_sgn & rs2_data[XLEN-1];
    assign a_abs   = a_neg ? (~rs1_data + ONE) : rs1_data;
    assign b_abs   = b_neg ? (~rs2_data + ONE) : rs2_data;
    assign res_neg = (funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
    assign div0    = is_div && (rs2_data == '0);
    assign ovf     = ((funct3 == 3'b100) || (funct3 == 3'b110)) && (rs1_data == SMIN) && (rs2_data == '1);
    assign fast    = div0 | ovf;

    always_comb begin
        fast_val = '0;
        if (div0)     fast_val = funct3[1] ? rs1_data : '1;
        else if (ovf) fast_val = funct3[1] ? '0 : rs1_data;
    end

    // Iteration datapath; prod_q[XLEN-1:0] holds the multiplier or the dividend/quotient
    logic [XLEN:0] mul_sum, div_shl, div_diff;
    logic          qbit;

    assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    assign div_shl  = {rem_q, prod_q[XLEN-1]};
    assign div_diff = div_shl - {1'b0, opb_q};
    assign qbit     = ~div_diff[XLEN];

    // Sign fix-up: multiply negates the full double-width product before selecting a half
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    assign prod_fix = neg_q ? (~prod_q + ONE2) : prod_q;
    assign quo_fix  = neg_q ? (~prod_q[XLEN-1:0] + ONE) : prod_q[XLEN-1:0];
    assign rem_fix  = neg_q ? (~rem_q + ONE) : rem_q;

    always_comb begin
        case (op_q)
            3'b000:                 fix_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quo_fix;
            default:                fix_val = rem_fix;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) state_d = fast ? DONE : CALC;
                CALC: if (cnt_q == CW'(XLEN-1)) state_d = FIX;
                FIX:  state_d = DONE;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy         = (state_q == CALC) || (state_q == FIX);
        result_valid = (state_q == DONE) && !flush;
    end
    assign result = result_q;

    always_comb begin
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        opb_d    = opb_q;
        result_d = result_q;
        if (!flush) begin
            case (state_q)
                IDLE: if (start) begin
                    op_d   = funct3;
                    neg_d  = res_neg;
                    cnt_d  = '0;
                    rem_d  = '0;
                    prod_d = {{XLEN{1'b0}}, is_div ? a_abs : b_abs};
                    opb_d  = is_div ? b_abs : a_abs;
                    if (fast) result_d = fast_val;
                end
                CALC: begin
                    cnt_d = cnt_q + 1'b1;
                    if (op_q[2]) begin
                        rem_d  = qbit ? div_diff[XLEN-1:0] : div_shl[XLEN-1:0];
                        prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], qbit};
                    end else begin
                        prod_d = {mul_sum, prod_q[XLEN-1:1]};
                    end
                end
                FIX: result_d = fix_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end
endmodule
